// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    // Width of the nibble index counter: clog2(n), never less than 1 bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bla_sub_4bit.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = x - y - bin.
// Computed as x + ~y + ~bin with flat (non-rippled) carry expansion.
module bla_sub_4bit
    import sub_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate on x + ~y, carries expanded two-level, borrow = ~carry.
    always_comb begin
        g    = x & ~y;
        p    = x ^ ~y;
        c[0] = ~bin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        d    = p ^ c[3:0];
        bout = ~c[4];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one nibble per clock through a single
// borrow-lookahead slice, valid/ready on both sides.
// Optional zero/ovf flag logic is enabled by defining SUB_FLAGS_EN; otherwise
// the flag ports are tied to 0. WIDTH must be a multiple of 4 and >= 4.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int N    = WIDTH / NIBBLE;
    localparam int IDXW = idx_width(N);
    localparam int MSB  = WIDTH - 1;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_q, b_q, diff_q, diff_nxt;
    logic              bin_q, borrow_q, out_valid_q;
    logic [3:0]        sx, sy, sd;
    logic              sbout;
    logic              accept, last, res_hs;

    // in_ready is the only unregistered output: decoded from state and rst.
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign last     = (state == RUN) && (idx == IDXW'(N - 1));
    assign res_hs   = out_valid_q && out_ready;

    // Select the current nibble of each latched operand and splice the
    // slice result into the running difference.
    always_comb begin
        sx       = a_q[idx*NIBBLE +: NIBBLE];
        sy       = b_q[idx*NIBBLE +: NIBBLE];
        diff_nxt = diff_q;
        diff_nxt[idx*NIBBLE +: NIBBLE] = sd;
    end

    bla_sub_4bit u_slice (
        .x    (sx),
        .y    (sy),
        .bin  (bin_q),
        .d    (sd),
        .bout (sbout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    if (res_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, per-nibble update, result and valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bin_q       <= 1'b0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
            idx         <= '0;
        end else begin
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                diff_q <= '0;
                bin_q  <= 1'b0;
                idx    <= '0;
            end
            if (state == RUN) begin
                diff_q <= diff_nxt;
                bin_q  <= sbout;
                if (last) begin
                    borrow_q    <= sbout;
                    out_valid_q <= 1'b1;
                    idx         <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (res_hs) out_valid_q <= 1'b0;
        end
    end

    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign out_valid = out_valid_q;

`ifdef SUB_FLAGS_EN
    logic zero_q, ovf_q;

    // Flags are taken from the completed difference as the last nibble lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last) begin
            zero_q <= (diff_nxt == '0);
            ovf_q  <= (a_q[MSB] ^ b_q[MSB]) & (diff_nxt[MSB] ^ a_q[MSB]);
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: directed cases, back-pressure, mid-run reset and
// randomized operands against an arithmetic reference model.
module tb_nibble_serial_subtractor;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow, zero, ovf;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model from plain integer arithmetic.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] ed, output logic eb,
                                  output logic ez, output logic eo);
        int ua, ub, sa, sb, sd;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ed = W'((ua - ub) & ((1 << W) - 1));
        eb = (ua < ub);
        sd = sa - sb;
`ifdef SUB_FLAGS_EN
        ez = (ed == 0);
        eo = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
`else
        ez = 1'b0;
        eo = 1'b0;
`endif
    endfunction

    // Issue one operation, check latency and result, hold back-pressure
    // for 'hold' cycles (with ignored in_valid pulses), then release.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int hold);
        logic [W-1:0] ed;
        logic eb, ez, eo;
        int cyc;
        model(oa, ob, ed, eb, ez, eo);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; a = oa; b = ob;
        @(negedge clk);
        in_valid = 1'b0; a = ~oa; b = ~ob;
        chk("in_ready_run", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, N);
        chk("diff", diff, ed);
        chk("borrow", borrow, eb);
        chk("zero", zero, ez);
        chk("ovf", ovf, eo);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_diff", diff, ed);
            chk("bp_flags", {borrow, zero, ovf}, {eb, ez, eo});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outs", {out_valid, borrow, zero, ovf}, 0);
        chk("rst_diff", diff, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);

        run_op(16'h1234, 16'h0234, 0);
        run_op(16'h0000, 16'h0001, 0);
        run_op(16'h8000, 16'h0001, 0);
        run_op(16'hBEEF, 16'hBEEF, 0);
        run_op(16'h7FFF, 16'hFFFF, 5);

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h9999; b = 16'h1111;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", in_ready, 1);
        repeat (N + 2) @(negedge clk);
        chk("midrst_no_result", out_valid, 0);
        run_op(16'h0005, 16'h0003, 0);

        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (k % 8 == 0) rb = ra;
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
